// File: rtl/event_counter_db.sv
// event_counter_db
//   Debounced push-button event counter. key_i[0] is synchronised and
//   debounced. Each accepted press latches the switch bank onto the LEDs and
//   steps an up/down counter. The counter wraps or saturates at its limits
//   (WRAP). The counter is shown on DIGITS active-low 7-segment hex digits,
//   and a sticky flag records any wrap or saturation event.
//
// Ports
//   clk100_i : 100 MHz clock, all state on the rising edge
//   key_i[1] : asynchronous active-low reset
//   key_i[0] : press button, active-low, asynchronous to clk100_i
//   sw_i     : switch bank, sampled on an accepted press
//   dir_i    : count direction (0 = up, 1 = down), sampled on an accepted press
//   ledr_o   : switch value latched at the last accepted press
//   hex_o    : digit k at [7k+6:7k], segments {g,f,e,d,c,b,a}, active-low
//   ovf_o    : sticky wrap/saturation flag, cleared only by reset
//   press_o  : one-cycle pulse per accepted press
module event_counter_db #(
  parameter int SW_W         = 14,
  parameter int DIGITS       = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int WRAP         = 1
) (
  input  logic                  clk100_i,
  input  logic [1:0]            key_i,
  input  logic [SW_W-1:0]       sw_i,
  input  logic                  dir_i,
  output logic [SW_W-1:0]       ledr_o,
  output logic [7*DIGITS-1:0]   hex_o,
  output logic                  ovf_o,
  output logic                  press_o
);

  localparam int CNT_W = 4 * DIGITS;
  localparam int DB_W  = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic                   rst_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   db_q;
  logic                   db_d1_q;
  logic [DB_W-1:0]        db_cnt_q;
  logic [CNT_W-1:0]       count_q;

  assign rst_n = key_i[1];

  // Synchroniser: released (1) on reset; s is the last stage.
  always_ff @(posedge clk100_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_i[0]};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce: db follows s only after DEBOUNCE_CYC consecutive cycles of
  // disagreement. The counter restarts whenever s agrees with db again.
  always_ff @(posedge clk100_i or negedge rst_n) begin
    if (!rst_n) begin
      db_q     <= 1'b1;
      db_cnt_q <= '0;
    end else if (s == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_q     <= s;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  // Press detect: registered pulse on the cycle after db falls.
  always_ff @(posedge clk100_i or negedge rst_n) begin
    if (!rst_n) begin
      db_d1_q <= 1'b1;
      press_o <= 1'b0;
    end else begin
      db_d1_q <= db_q;
      press_o <= db_d1_q & ~db_q;
    end
  end

  // Counter, LED latch and sticky overflow, all stepped by press_o.
  always_ff @(posedge clk100_i or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ledr_o  <= '0;
      ovf_o   <= 1'b0;
    end else if (press_o) begin
      ledr_o <= sw_i;
      if (!dir_i) begin
        if (count_q != '1) begin
          count_q <= count_q + CNT_W'(1);
        end else begin
          ovf_o <= 1'b1;
          if (WRAP != 0) count_q <= '0;
        end
      end else begin
        if (count_q != '0) begin
          count_q <= count_q - CNT_W'(1);
        end else begin
          ovf_o <= 1'b1;
          if (WRAP != 0) count_q <= '1;
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  always_comb begin
    hex_o = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      hex_o[7*k +: 7] = seg7(count_q[4*k +: 4]);
    end
  end

endmodule

// File: tb/tb_event_counter_db.sv
module tb_event_counter_db;

  logic        clk;
  logic [1:0]  key;
  logic [13:0] sw;
  logic        dir;

  logic [13:0] ledr_w, ledr_s;
  logic [13:0] hex_w, hex_s;
  logic        ovf_w, ovf_s;
  logic        press_w, press_s;

  int total = 0;
  int bad   = 0;
  int pw    = 0;
  int ps    = 0;

  // reference model state
  int          mw, ms;
  bit          movw, movs;
  logic [13:0] mled;
  int          exp_p;

  logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [13:0] sw;
    logic        dir;
    logic [7:0]  cw;
    logic [7:0]  cs;
    logic        ow;
    logic        os;
  } vec_t;

  vec_t tbl [5];

  event_counter_db #(.SW_W(14), .DIGITS(2), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .WRAP(1)) u_wrap (
    .clk100_i(clk), .key_i(key), .sw_i(sw), .dir_i(dir),
    .ledr_o(ledr_w), .hex_o(hex_w), .ovf_o(ovf_w), .press_o(press_w)
  );

  event_counter_db #(.SW_W(14), .DIGITS(2), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .WRAP(0)) u_sat (
    .clk100_i(clk), .key_i(key), .sw_i(sw), .dir_i(dir),
    .ledr_o(ledr_s), .hex_o(hex_s), .ovf_o(ovf_s), .press_o(press_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (press_w) pw++;
    if (press_s) ps++;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

  function automatic logic [13:0] hexof(input int c);
    return {seg[(c >> 4) & 15], seg[c & 15]};
  endfunction

  function automatic int step(input int c, input bit down, input bit wrap, inout bit ov);
    int nc;
    nc = down ? c - 1 : c + 1;
    if (nc > 255 || nc < 0) begin
      ov = 1'b1;
      nc = wrap ? (nc & 255) : c;
    end
    return nc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hex_w"}, 32'(hex_w), 32'(hexof(mw)));
    chk({tag, ".ovf_w"}, 32'(ovf_w), 32'(movw));
    chk({tag, ".hex_s"}, 32'(hex_s), 32'(hexof(ms)));
    chk({tag, ".ovf_s"}, 32'(ovf_s), 32'(movs));
    chk({tag, ".ledr_w"}, 32'(ledr_w), 32'(mled));
    chk({tag, ".ledr_s"}, 32'(ledr_s), 32'(mled));
    chk({tag, ".press_w"}, 32'(pw), 32'(exp_p));
    chk({tag, ".press_s"}, 32'(ps), 32'(exp_p));
  endtask

  task automatic model_press(input logic [13:0] s, input bit d);
    mled = s;
    mw = step(mw, d, 1'b1, movw);
    ms = step(ms, d, 1'b0, movs);
    exp_p++;
  endtask

  task automatic model_reset();
    mw = 0; ms = 0; movw = 0; movs = 0; mled = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 key[1] = 1'b0;
    #11 key[1] = 1'b1;
    model_reset();
  endtask

  task automatic press(input logic [13:0] s, input bit d, input int hold, input int gap);
    @(negedge clk);
    sw = s; dir = d; key[0] = 1'b0;
    repeat (hold) @(negedge clk);
    key[0] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int first;
    int r;
    key = 2'b01; sw = '0; dir = 1'b0;
    model_reset();
    exp_p = 0;
    #11 key[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.hex", 32'(hex_w), 32'h2040);
    check_all("reset");

    // clean press: pulse 6 cycles after first low sample
    @(negedge clk);
    sw = 14'h1A5C; dir = 1'b0; key[0] = 1'b0;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (press_w && first < 0) first = i;
    end
    key[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("clean.latency", 32'(first), 32'd6);
    model_press(14'h1A5C, 1'b0);
    chk("clean.digit0", 32'(hex_w[6:0]), 32'h79);
    check_all("clean");

    // table of presses continuing from count=1
    tbl[0] = '{14'h0333, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{14'h2AAA, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1};
    tbl[2] = '{14'h1111, 1'b0, 8'h00, 8'h01, 1'b1, 1'b1};
    tbl[3] = '{14'h0F0F, 1'b0, 8'h01, 8'h02, 1'b1, 1'b1};
    tbl[4] = '{14'h3FFF, 1'b0, 8'h02, 8'h03, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      press(tbl[i].sw, tbl[i].dir, 8, 10);
      model_press(tbl[i].sw, tbl[i].dir);
      chk("tbl.hex_w", 32'(hex_w), 32'(hexof(int'(tbl[i].cw))));
      chk("tbl.hex_s", 32'(hex_s), 32'(hexof(int'(tbl[i].cs))));
      chk("tbl.ovf_w", 32'(ovf_w), 32'(tbl[i].ow));
      chk("tbl.ovf_s", 32'(ovf_s), 32'(tbl[i].os));
      chk("tbl.ledr", 32'(ledr_w), 32'(tbl[i].sw));
    end

    // bouncing edge then held low: one press
    @(negedge clk);
    sw = 14'h0777; dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key[0] = 1'b0; repeat (2) @(negedge clk);
      key[0] = 1'b1; repeat (2) @(negedge clk);
    end
    key[0] = 1'b0; repeat (10) @(negedge clk);
    key[0] = 1'b1; repeat (10) @(negedge clk);
    model_press(14'h0777, 1'b0);
    check_all("bounce");

    // 3-cycle glitch: nothing
    sw = 14'h2222;
    key[0] = 1'b0; repeat (3) @(negedge clk);
    key[0] = 1'b1; repeat (10) @(negedge clk);
    check_all("glitch");

    // held key: exactly one press
    press(14'h0123, 1'b1, 40, 10);
    model_press(14'h0123, 1'b1);
    check_all("held");

    // switch/direction changes without a press
    for (int i = 0; i < 10; i++) begin
      sw = 14'($urandom); dir = 1'($urandom);
      repeat (5) @(negedge clk);
    end
    check_all("idle");

    // reset while debounce is mid-count
    @(negedge clk);
    sw = 14'h0555; dir = 1'b0; key[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 key[1] = 1'b0;
    #11 key[1] = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("midrst.early");
    repeat (12) @(negedge clk);
    key[0] = 1'b1;
    repeat (10) @(negedge clk);
    model_press(14'h0555, 1'b0);
    check_all("midrst.late");

    // wrap / saturate at the top
    do_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 255; i++) begin
      press(14'h0001, 1'b0, 5, 9);
      model_press(14'h0001, 1'b0);
    end
    chk("wrap.ff", 32'(hex_w), 32'(hexof(255)));
    check_all("wrap.max");
    press(14'h0002, 1'b0, 5, 9);
    model_press(14'h0002, 1'b0);
    chk("wrap.zero", 32'(hex_w), 32'(hexof(0)));
    check_all("wrap.over");
    press(14'h0003, 1'b1, 5, 9);
    model_press(14'h0003, 1'b1);
    check_all("wrap.down");

    // randomised operations against the model
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        logic [13:0] rs;
        bit rd;
        rs = 14'($urandom);
        rd = 1'($urandom);
        press(rs, rd, int'($urandom_range(5, 14)), int'($urandom_range(9, 14)));
        model_press(rs, rd);
      end else if (r < 8) begin
        @(negedge clk);
        sw = 14'($urandom);
        key[0] = 1'b0;
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
        key[0] = 1'b1;
        repeat (8) @(negedge clk);
      end else begin
        sw = 14'($urandom); dir = 1'($urandom);
        repeat (4) @(negedge clk);
      end
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
